// File: rtl/mem_resp.sv
// Single-port-write / single-port-read memory with a self-clearing INIT phase,
// one-cycle read latency, write-first collision handling and a served-read counter.
module mem_resp #(
  parameter int DW         = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  rd_req,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DW-1:0]         rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DW-1:0]         wr_data,
  output logic [15:0]           rd_count
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  state_t                  state, next_state;
  logic [DEPTH_LOG2-1:0]   clr_ptr;
  logic [DW-1:0]           mem [2**DEPTH_LOG2];

  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_waddr;
  logic [DW-1:0]           mem_wdata;
  logic                    rd_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= next_state;
  end

  // Leave INIT on the same edge that clears the final location.
  always_comb begin
    next_state = state;
    if (state == INIT && clr_ptr == '1) next_state = READY;
  end

  assign ready     = (state == READY);
  assign rd_accept = ready && rd_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                clr_ptr <= '0;
    else if (state == INIT) clr_ptr <= clr_ptr + PTR_ONE;
  end

  // While INIT the clear pointer owns the write port; user writes are dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr;
      mem_wdata = '0;
    end else if (wr_en) begin
      mem_we = 1'b1;
    end
  end

  // The array has no reset; rst only blocks the write strobe.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Same-address collisions bypass the array so the read sees the new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_count <= '0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data  <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
        rd_count <= rd_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp: stimulus pushes expected reads, a negedge
// monitor pops and compares whenever rd_valid is seen.
module tb_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_count;

  typedef struct {
    logic [15:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_mem [256];
  logic [15:0] model_cnt;
  logic        model_ready;
  int          checks   = 0;
  int          failures = 0;

  mem_resp #(.DW(16), .DEPTH_LOG2(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_count (rd_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, update the reference model, then step past the edge.
  task automatic applyStimulus(input logic rq, input logic [7:0] ra,
                               input logic we, input logic [7:0] wa, input logic [15:0] wd);
    exp_t e;
    rd_req  = rq;
    rd_addr = ra;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    if (model_ready) begin
      if (rq) begin
        model_cnt = model_cnt + 16'd1;
        e.data = (we && wa == ra) ? wd : model_mem[ra];
        e.cnt  = model_cnt;
        sb.push_back(e);
      end
      if (we) model_mem[wa] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
  endtask

  // Assert reset off-edge, confirm outputs clear at once, then release.
  task automatic doReset();
    rst    = 1'b1;
    rd_req = 1'b0;
    wr_en  = 1'b0;
    #1;
    checkOutput("rst_ready",    {31'd0, ready},    32'd0);
    checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("rst_rd_data",  {16'd0, rd_data},  32'd0);
    checkOutput("rst_rd_count", {16'd0, rd_count}, 32'd0);
    sb.delete();
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    model_cnt   = 16'h0000;
    model_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitReady(input int expected);
    int n = 0;
    while (!ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("init_cycles", n, expected);
    model_ready = ready;
  endtask

  // Monitor: pop on every rd_valid, otherwise rd_data must hold.
  initial begin
    exp_t        e;
    logic [15:0] last_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_data = 16'h0000;
      end else if (rd_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rd_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rd_data",  {16'd0, rd_data},  {16'd0, e.data});
          checkOutput("rd_count", {16'd0, rd_count}, {16'd0, e.cnt});
        end
        last_data = rd_data;
      end else begin
        checkOutput("rd_data_hold", {16'd0, rd_data}, {16'd0, last_data});
      end
    end
  end

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_ready = 1'b0;
    model_cnt   = 16'h0000;

    // Power-on init and reads of cleared locations
    doReset();
    waitReady(256);
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00, 16'h0000);
    applyStimulus(1'b1, 8'h7F, 1'b0, 8'h00, 16'h0000);
    applyStimulus(1'b1, 8'hFF, 1'b0, 8'h00, 16'h0000);
    idle(2);

    // Requests during INIT must be ignored entirely
    doReset();
    for (int i = 0; i < 200; i++) applyStimulus(1'b1, 8'h05, 1'b1, 8'h05, 16'hBEEF);
    idle(0);
    rd_req = 1'b0;
    wr_en  = 1'b0;
    waitReady(56);
    checkOutput("init_no_count", {16'd0, rd_count}, 32'd0);
    applyStimulus(1'b1, 8'h05, 1'b0, 8'h00, 16'h0000);
    idle(1);

    // Write then read, and a same-edge write-first collision
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h10, 16'hA5A5);
    applyStimulus(1'b1, 8'h10, 1'b0, 8'h00, 16'h0000);
    idle(2);
    applyStimulus(1'b1, 8'h20, 1'b1, 8'h20, 16'h1234);
    idle(2);

    // Reset with a read in flight
    applyStimulus(1'b1, 8'h10, 1'b0, 8'h00, 16'h0000);
    doReset();
    waitReady(256);

    // Reset while the clear pointer sits at 0x80
    doReset();
    idle(128);
    doReset();
    waitReady(256);

    // Continuous reads across a full count wrap, with independent writes early on
    for (int i = 0; i < 65540; i++) begin
      if (i < 512)
        applyStimulus(1'b1, 8'(i), 1'b1, 8'(i + 5), 16'(i) ^ 16'h5A5A);
      else
        applyStimulus(1'b1, 8'(i), 1'b0, 8'h00, 16'h0000);
    end
    idle(3);

    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
